wb_sid_bridge: RTL and testbench
================================

Name: wb_sid_bridge

Overview:
- Parametrised Wishbone slave that fronts NUM_CHIPS external SID 6581 cores from one 8-bit Wishbone bus.
- Each chip has a 32-byte window. Reads of the write-only registers return values from a shadow register file.
- CPU writes are queued in a shared FIFO and drained to the cores at a paced rate, one write per CLK_DIV system clocks. A CPU burst never outruns the 1 MHz SID core.
- Sits between the SPI/Wishbone bridge and the sid6581 instances.

Parameters:
- NUM_CHIPS, 2, number of SID cores served (1..8); selected by wb_adr_i[7:5].
- FIFO_DEPTH, 16, write-queue depth in entries; power of two, 4..64.
- CLK_DIV, 32, system clocks per drain slot (32 MHz / 1 MHz); must be >= 2.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wb_adr_i  in  8  [7:5] chip index, [4:0] SID register
- wb_dat_i  in  8  write data
- wb_dat_o  out  8  registered read data
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_ack_o  out  1  single-cycle acknowledge
- sid_rdata_i  in  8*NUM_CHIPS  live read data from each core, chip k at [8k+7:8k]
- sid_cs_o  out  NUM_CHIPS  one-hot write strobe per core
- sid_we_o  out  1  write enable to cores
- sid_addr_o  out  5  register address to cores
- sid_dat_o  out  8  write data to cores
- fifo_level_o  out  7  current queue occupancy

Behaviour:
- Reset (async, rst_n=0):
  - wb_ack_o=0, wb_dat_o=0x00, sid_cs_o=0, sid_we_o=0, sid_addr_o=0, sid_dat_o=0.
  - FIFO empty, level 0; divider counter 0; all shadow bytes 0x00.
  - Reset mid-drain or mid-cycle abandons queued writes; no strobe is emitted after reset.
- Request valid: valid = wb_cyc_i & wb_stb_i & ~wb_ack_o.
- Ack:
  - wb_ack_o rises the cycle after a request is accepted and lasts exactly one cycle.
  - Back-to-back requests are spaced by at least 1 idle-ack cycle.
- Read accepted immediately; wb_dat_o is loaded in the same edge as the ack, then held until the next read.
  - Reg 0x00-0x18: shadow byte for the selected chip.
  - Reg 0x19-0x1C: sid_rdata_i of the selected chip, sampled at acceptance.
  - Reg 0x1D-0x1E: 0x00.
  - Reg 0x1F (status, any chip): bit7 = FIFO full, bits6:0 = level.
  - Chip index >= NUM_CHIPS: 0x00.
- Write, reg 0x00-0x18 on a valid chip:
  - Accepted only when the FIFO is not full at that cycle; if full, no ack until a slot frees (stall).
  - On acceptance the shadow byte updates and the entry {chip[2:0], addr[4:0], data[7:0]} is pushed.
- Write, any other address (0x19-0x1F, or invalid chip): accepted immediately, acked, no side effect.
- Full test is registered-state based: push and pop in the same cycle when full is not allowed (push waits). Push and pop in the same cycle otherwise leave the level unchanged.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick = (count == CLK_DIV-1).
  - Free-running, independent of FIFO state.
- Drain:
  - On a tick with the FIFO non-empty, pop the head entry.
  - Next cycle: sid_cs_o[chip]=1 and sid_we_o=1 for exactly one clock; sid_addr_o and sid_dat_o take the entry.
  - sid_addr_o and sid_dat_o hold until the next pop.
  - On a tick with the FIFO empty, no strobe.
  - At most one core write per CLK_DIV clocks; FIFO order is preserved across chips.
- Pointers: wrap modulo FIFO_DEPTH. fifo_level_o ranges 0..FIFO_DEPTH and is 64 at maximum depth.
- Shadow reflects the CPU's view immediately, before the queued write reaches the core. This is intended.

Test Plan:
- Reset, then read chip0 reg 0x04 and reg 0x1F -> wb_dat_o=0x00 both, ack 1 cycle after stb each.
- Write chip1 reg 0x00=0xA5 -> ack next cycle; level=1; within CLK_DIV+1 clocks sid_cs_o=0b10, sid_we_o=1 for 1 clk, sid_addr_o=0x00, sid_dat_o=0xA5. Read back chip1 reg 0x00 -> 0xA5.
- 17 back-to-back writes with FIFO_DEPTH=16 -> first 16 acked, level=16, status=0x90; 17th ack withheld until first pop, then acked. All 17 appear on sid bus in order, spaced exactly CLK_DIV clocks.
- Read chip0 reg 0x1B with sid_rdata_i[7:0]=0x3C -> wb_dat_o=0x3C. Write 0x55 to reg 0x1B -> acked, level unchanged, no sid strobe.
- NUM_CHIPS=2, access chip 5 -> writes acked with no push, reads return 0x00, bus never hangs.
- Queue 8 writes, assert rst_n=0 mid-drain for 1 clk -> outputs reset immediately; no further sid_cs_o pulses; level=0; shadows read 0x00.

Source files
------------

// File: rtl/wb_sid_bridge.sv
// Wishbone slave fronting NUM_CHIPS SID cores: shadowed write-only registers,
// live read-back registers, and a shared write queue drained one entry per CLK_DIV clocks.
module wb_sid_bridge #(
    parameter int NUM_CHIPS  = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             wb_adr_i,
    input  logic [7:0]             wb_dat_i,
    output logic [7:0]             wb_dat_o,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    output logic                   wb_ack_o,
    input  logic [8*NUM_CHIPS-1:0] sid_rdata_i,
    output logic [NUM_CHIPS-1:0]   sid_cs_o,
    output logic                   sid_we_o,
    output logic [4:0]             sid_addr_o,
    output logic [7:0]             sid_dat_o,
    output logic [6:0]             fifo_level_o
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(CLK_DIV);
    localparam int NSH = NUM_CHIPS * 25;

    logic [15:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;
    logic [CW-1:0]    div_cnt;
    logic [NSH*8-1:0] shadow;

    logic [2:0]  chip;
    logic [4:0]  sreg;
    logic        chip_ok;
    logic        shadow_reg;
    logic        req;
    logic        wr_q;
    logic        full;
    logic        empty;
    logic        tick;
    logic        accept;
    logic        push;
    logic        pop_p0;
    logic [15:0] head;
    logic [7:0]  rd_val;
    int          sh_idx;
    int          rd_idx;

    assign chip       = wb_adr_i[7:5];
    assign sreg       = wb_adr_i[4:0];
    assign chip_ok    = int'(chip) < NUM_CHIPS;
    assign shadow_reg = chip_ok && (sreg <= 5'h18);
    assign sh_idx     = shadow_reg ? int'(chip) * 25 + int'(sreg) : 0;
    assign rd_idx     = chip_ok ? int'(chip) : 0;

    assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign full   = (level == (AW+1)'(FIFO_DEPTH));
    assign empty  = (level == '0);
    assign tick   = (div_cnt == CW'(CLK_DIV - 1));
    // Only queued writes can stall; full is taken from registered state, so a pop this cycle does not help.
    assign wr_q   = req & wb_we_i & shadow_reg;
    assign accept = req & (~wr_q | ~full);
    assign push   = wr_q & ~full;
    assign pop_p0 = tick & ~empty;
    assign head   = fifo_mem[rd_ptr];

    assign fifo_level_o = 7'(level);

    always_comb begin
        rd_val = 8'h00;
        if (sreg == 5'h1F)
            rd_val = {full, fifo_level_o};
        else if (shadow_reg)
            rd_val = shadow[sh_idx*8 +: 8];
        else if (chip_ok && sreg <= 5'h1C)
            rd_val = sid_rdata_i[rd_idx*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {chip, sreg, wb_dat_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack_o   <= 1'b0;
            wb_dat_o   <= 8'h00;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            div_cnt    <= '0;
            shadow     <= '0;
            sid_cs_o   <= '0;
            sid_we_o   <= 1'b0;
            sid_addr_o <= 5'h00;
            sid_dat_o  <= 8'h00;
        end else begin
            wb_ack_o <= accept;
            if (accept && !wb_we_i)
                wb_dat_o <= rd_val;

            if (push) begin
                wr_ptr                   <= wr_ptr + AW'(1);
                shadow[sh_idx*8 +: 8]    <= wb_dat_i;
            end
            if (pop_p0)
                rd_ptr <= rd_ptr + AW'(1);

            if (push && !pop_p0)
                level <= level + (AW+1)'(1);
            else if (pop_p0 && !push)
                level <= level - (AW+1)'(1);

            div_cnt <= tick ? '0 : div_cnt + CW'(1);

            // Strobe stage: one-clock pulse following the pop; address/data persist until the next pop.
            sid_cs_o <= '0;
            sid_we_o <= pop_p0;
            if (pop_p0) begin
                sid_cs_o   <= NUM_CHIPS'(1) << head[15:13];
                sid_addr_o <= head[12:8];
                sid_dat_o  <= head[7:0];
            end
        end
    end
endmodule

// File: tb/tb_wb_sid_bridge.sv
// Bench for wb_sid_bridge: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_wb_sid_bridge;
    localparam int NUM_CHIPS  = 2;
    localparam int FIFO_DEPTH = 16;
    localparam int CLK_DIV    = 32;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [7:0]             wb_adr_i = 8'h00;
    logic [7:0]             wb_dat_i = 8'h00;
    logic                   wb_cyc_i = 1'b0;
    logic                   wb_stb_i = 1'b0;
    logic                   wb_we_i = 1'b0;
    logic [8*NUM_CHIPS-1:0] sid_rdata_i = '0;
    logic [7:0]             wb_dat_o;
    logic                   wb_ack_o;
    logic [NUM_CHIPS-1:0]   sid_cs_o;
    logic                   sid_we_o;
    logic [4:0]             sid_addr_o;
    logic [7:0]             sid_dat_o;
    logic [6:0]             fifo_level_o;

    wb_sid_bridge #(.NUM_CHIPS(NUM_CHIPS), .FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
        .sid_rdata_i(sid_rdata_i), .sid_cs_o(sid_cs_o), .sid_we_o(sid_we_o),
        .sid_addr_o(sid_addr_o), .sid_dat_o(sid_dat_o), .fifo_level_o(fifo_level_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the write queue is a plain queue, shadows a 2-D array,
    // and drain slots fall on every CLK_DIV-th clock counted since reset release.
    logic [15:0]          m_q[$];
    logic [7:0]           m_sh [8][32];
    int                   m_cyc = 0;
    logic                 m_ack = 1'b0;
    logic                 m_we = 1'b0;
    logic [7:0]           m_dat = 8'h00;
    logic [7:0]           m_sdat = 8'h00;
    logic [4:0]           m_addr = 5'h00;
    logic [NUM_CHIPS-1:0] m_cs = '0;

    task automatic model_step();
        int         c     = int'(wb_adr_i[7:5]);
        int         r     = int'(wb_adr_i[4:0]);
        int         sz    = m_q.size();
        bit         full  = (sz == FIFO_DEPTH);
        bit         slot  = (m_cyc % CLK_DIV) == CLK_DIV - 1;
        bit         valid = wb_cyc_i && wb_stb_i && !m_ack;
        bit         shreg = (c < NUM_CHIPS) && (r <= 24);
        bit         acc   = valid && !(wb_we_i && shreg && full);
        logic [15:0] ent;
        if (acc && !wb_we_i) begin
            if (r == 31)                      m_dat = {full, 7'(sz)};
            else if (c >= NUM_CHIPS || r >= 29) m_dat = 8'h00;
            else if (r <= 24)                 m_dat = m_sh[c][r];
            else                              m_dat = sid_rdata_i[c*8 +: 8];
        end
        m_cs = '0;
        m_we = 1'b0;
        if (slot && sz > 0) begin
            ent    = m_q.pop_front();
            m_cs   = NUM_CHIPS'(1) << ent[15:13];
            m_we   = 1'b1;
            m_addr = ent[12:8];
            m_sdat = ent[7:0];
        end
        if (acc && wb_we_i && shreg) begin
            m_q.push_back({wb_adr_i, wb_dat_i});
            m_sh[c][r] = wb_dat_i;
        end
        m_ack = acc;
        m_cyc++;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_q.delete();
            foreach (m_sh[c, r]) m_sh[c][r] = 8'h00;
            m_cyc = 0; m_ack = 1'b0; m_we = 1'b0; m_dat = 8'h00;
            m_sdat = 8'h00; m_addr = 5'h00; m_cs = '0;
        end else begin
            model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        chk("ack",      32'(wb_ack_o),     32'(m_ack));
        chk("rdata",    32'(wb_dat_o),     32'(m_dat));
        chk("sid_cs",   32'(sid_cs_o),     32'(m_cs));
        chk("sid_we",   32'(sid_we_o),     32'(m_we));
        chk("sid_addr", 32'(sid_addr_o),   32'(m_addr));
        chk("sid_dat",  32'(sid_dat_o),    32'(m_sdat));
        chk("level",    32'(fifo_level_o), 32'(m_q.size()));
        if (sid_cs_o != '0) pulses++;
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic bus(input bit we, input logic [7:0] adr, input logic [7:0] dat,
                       output logic [7:0] rd, output int lat);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
        lat = 0;
        do begin @(posedge clk); #2; lat++; end while (!wb_ack_o && lat < 400);
        chk("ack_seen", 32'(wb_ack_o), 32'h1);
        rd = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wait_empty(input int limit);
        int w = 0;
        while (fifo_level_o != 7'd0 && w < limit) begin @(posedge clk); #2; w++; end
        chk("drain_done", 32'(fifo_level_o), 32'h0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int lat;
        int maxlvl;
        int p0;
        int w;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ack", 32'(wb_ack_o), 32'h0);
        chk("rst_level", 32'(fifo_level_o), 32'h0);
        rst_n = 1'b1;
        idle(1);

        bus(1'b0, 8'h04, 8'h00, rd, lat);
        chk("rd_c0r4", 32'(rd), 32'h00);
        chk("rd_c0r4_lat", 32'(lat), 32'h1);
        idle(1);
        bus(1'b0, 8'h1F, 8'h00, rd, lat);
        chk("rd_status_empty", 32'(rd), 32'h00);
        chk("rd_status_lat", 32'(lat), 32'h1);
        idle(1);

        bus(1'b1, 8'h20, 8'hA5, rd, lat);
        chk("wr_lat", 32'(lat), 32'h1);
        chk("wr_level1", 32'(fifo_level_o), 32'h1);
        w = 0;
        while (sid_cs_o == '0 && w < CLK_DIV + 2) begin @(posedge clk); #2; w++; end
        chk("strobe_in_time", 32'(w <= CLK_DIV + 1), 32'h1);
        chk("strobe_cs", 32'(sid_cs_o), 32'h2);
        chk("strobe_we", 32'(sid_we_o), 32'h1);
        chk("strobe_addr", 32'(sid_addr_o), 32'h00);
        chk("strobe_dat", 32'(sid_dat_o), 32'hA5);
        idle(1);
        chk("strobe_one_clk", 32'(sid_cs_o), 32'h0);
        chk("strobe_hold_dat", 32'(sid_dat_o), 32'hA5);
        bus(1'b0, 8'h20, 8'h00, rd, lat);
        chk("readback_c1r0", 32'(rd), 32'hA5);
        idle(1);

        maxlvl = 0;
        for (int i = 0; i < 24; i++) begin
            bus(1'b1, {3'(i % 2), 5'(i % 25)}, 8'(i * 7 + 1), rd, lat);
            if (int'(fifo_level_o) > maxlvl) maxlvl = int'(fifo_level_o);
        end
        chk("burst_max_level", 32'(maxlvl), 32'd16);
        chk("burst_last_stalled", 32'(lat > 2), 32'h1);
        bus(1'b0, 8'h1F, 8'h00, rd, lat);
        chk("status_full", 32'(rd), 32'h90);
        wait_empty(30 * CLK_DIV);
        idle(2);

        sid_rdata_i = 16'h003C;
        bus(1'b0, 8'h1B, 8'h00, rd, lat);
        chk("rd_live_1b", 32'(rd), 32'h3C);
        idle(1);
        p0 = pulses;
        bus(1'b1, 8'h1B, 8'h55, rd, lat);
        chk("wr_1b_lat", 32'(lat), 32'h1);
        chk("wr_1b_level", 32'(fifo_level_o), 32'h0);
        idle(1);
        bus(1'b1, {3'd5, 5'd3}, 8'h77, rd, lat);
        chk("wr_badchip_lat", 32'(lat), 32'h1);
        chk("wr_badchip_level", 32'(fifo_level_o), 32'h0);
        idle(1);
        bus(1'b0, {3'd5, 5'd3}, 8'h00, rd, lat);
        chk("rd_badchip", 32'(rd), 32'h00);
        idle(2 * CLK_DIV);
        chk("no_strobe_unqueued", 32'(pulses - p0), 32'h0);

        for (int i = 0; i < 8; i++) bus(1'b1, 8'(i), 8'(8'h40 + i), rd, lat);
        p0 = pulses;
        w = 0;
        while (pulses == p0 && w < 3 * CLK_DIV) begin @(posedge clk); #2; w++; end
        chk("drain_started", 32'(pulses > p0), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_level", 32'(fifo_level_o), 32'h0);
        chk("rst_async_cs", 32'(sid_cs_o), 32'h0);
        chk("rst_async_dat", 32'(sid_dat_o), 32'h00);
        @(posedge clk); #2;
        rst_n = 1'b1;
        p0 = pulses;
        idle(3 * CLK_DIV);
        chk("no_strobe_after_rst", 32'(pulses - p0), 32'h0);
        chk("level_after_rst", 32'(fifo_level_o), 32'h0);
        bus(1'b0, 8'h03, 8'h00, rd, lat);
        chk("shadow_after_rst", 32'(rd), 32'h00);
        idle(1);

        for (int i = 0; i < 300; i++) begin
            logic [2:0] c;
            sid_rdata_i = (8*NUM_CHIPS)'($urandom);
            c = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) c = 3'($urandom_range(0, NUM_CHIPS - 1));
            bus(1'($urandom_range(0, 1)), {c, 5'($urandom_range(0, 31))}, 8'($urandom), rd, lat);
            idle($urandom_range(0, 3));
        end
        wait_empty(FIFO_DEPTH * CLK_DIV + 100);
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
